// File: rtl/ysyx_25020047_wbu_stage_if.sv
// Write-back stage bus: upstream entry handshake, decoded payload, register/PC
// write-back outputs and retire/halt status.
interface ysyx_25020047_wbu_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TYPEW = 32,
    parameter int unsigned CNTW  = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [TYPEW-1:0] inst_type;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  memdata;
    logic [XLEN-1:0]  snpc;
    logic [1:0]       addr_lo;
    logic [4:0]       rd;
    logic             out_valid;
    logic             out_ready;
    logic             wen;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  dnpc;
    logic             redirect;
    logic [CNTW-1:0]  retired;
    logic             halted;

    modport master (
        output in_valid, inst_type, result, memdata, snpc, addr_lo, rd, out_ready,
        input  in_ready, out_valid, wen, waddr, wdata, dnpc, redirect, retired, halted
    );

    modport slave (
        input  in_valid, inst_type, result, memdata, snpc, addr_lo, rd, out_ready,
        output in_ready, out_valid, wen, waddr, wdata, dnpc, redirect, retired, halted
    );
endinterface

// File: rtl/ysyx_25020047_wbu_stage.sv
// Write-back stage: decodes the result source per instruction class into a
// one-entry output register, counts retires, and halts after an ebreak drains.
module ysyx_25020047_wbu_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TYPEW = 32,
    parameter int unsigned CNTW  = 64
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_25020047_wbu_stage_if.slave bus
);
    localparam logic [TYPEW-1:0] T_ADDI   = TYPEW'(32'h0000_0001);
    localparam logic [TYPEW-1:0] T_JALR   = TYPEW'(32'h0000_0002);
    localparam logic [TYPEW-1:0] T_ADD    = TYPEW'(32'h0000_0008);
    localparam logic [TYPEW-1:0] T_LUI    = TYPEW'(32'h0000_0010);
    localparam logic [TYPEW-1:0] T_LW     = TYPEW'(32'h0000_0020);
    localparam logic [TYPEW-1:0] T_LBU    = TYPEW'(32'h0000_0040);
    localparam logic [TYPEW-1:0] T_AUIPC  = TYPEW'(32'h0000_0200);
    localparam logic [TYPEW-1:0] T_JAL    = TYPEW'(32'h0000_0400);
    localparam logic [TYPEW-1:0] T_SUB    = TYPEW'(32'h0000_0800);
    localparam logic [TYPEW-1:0] T_LH     = TYPEW'(32'h0000_1000);
    localparam logic [TYPEW-1:0] T_LHU    = TYPEW'(32'h0000_2000);
    localparam logic [TYPEW-1:0] T_LB     = TYPEW'(32'h0000_4000);
    localparam logic [TYPEW-1:0] T_EBREAK = TYPEW'(32'h0001_0000);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t          state;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] wb_val;
    logic            writes;
    logic            jump;
    logic            wen_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] dnpc_c;
    logic            capture;
    logic            retire;
    logic            is_ebreak;

    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign capture      = bus.in_valid && bus.in_ready;
    assign retire       = bus.out_valid && bus.out_ready;
    assign is_ebreak    = (bus.inst_type == T_EBREAK);

    // Byte/halfword lane selection for sub-word loads
    always_comb begin
        ld_byte = bus.memdata[7:0];
        case (bus.addr_lo)
            2'd1:    ld_byte = bus.memdata[15:8];
            2'd2:    ld_byte = bus.memdata[23:16];
            2'd3:    ld_byte = bus.memdata[31:24];
            default: ld_byte = bus.memdata[7:0];
        endcase
        ld_half = bus.addr_lo[1] ? bus.memdata[31:16] : bus.memdata[15:0];
    end

    // Result source select; store, ebreak and unrecognised codes write nothing
    always_comb begin
        wb_val = '0;
        writes = 1'b0;
        jump   = 1'b0;
        case (bus.inst_type)
            T_ADDI, T_ADD, T_LUI, T_AUIPC, T_SUB: begin
                wb_val = bus.result;
                writes = 1'b1;
            end
            T_JAL, T_JALR: begin
                wb_val = bus.snpc;
                writes = 1'b1;
                jump   = 1'b1;
            end
            T_LW: begin
                wb_val = bus.memdata;
                writes = 1'b1;
            end
            T_LBU: begin
                wb_val = {{(XLEN-8){1'b0}}, ld_byte};
                writes = 1'b1;
            end
            T_LB: begin
                wb_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                writes = 1'b1;
            end
            T_LHU: begin
                wb_val = {{(XLEN-16){1'b0}}, ld_half};
                writes = 1'b1;
            end
            T_LH: begin
                wb_val = {{(XLEN-16){ld_half[15]}}, ld_half};
                writes = 1'b1;
            end
            default: ;
        endcase
        wen_c   = writes && (bus.rd != 5'd0);
        wdata_c = wen_c ? wb_val : '0;
        dnpc_c  = jump ? bus.result : bus.snpc;
    end

    // Output register, retire counter and RUN/DRAIN/HALT sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            bus.out_valid <= 1'b0;
            bus.wen       <= 1'b0;
            bus.waddr     <= 5'd0;
            bus.wdata     <= '0;
            bus.dnpc      <= '0;
            bus.redirect  <= 1'b0;
            bus.retired   <= '0;
            bus.halted    <= 1'b0;
        end else begin
            if (retire) begin
                bus.retired <= bus.retired + CNTW'(1);
            end
            case (state)
                RUN: begin
                    if (capture && is_ebreak) state <= DRAIN;
                end
                DRAIN: begin
                    if (retire) begin
                        state      <= HALT;
                        bus.halted <= 1'b1;
                    end
                end
                HALT: begin
                    bus.halted <= 1'b1;
                end
                default: state <= RUN;
            endcase
            if (capture) begin
                bus.out_valid <= 1'b1;
                bus.wen       <= wen_c;
                bus.waddr     <= bus.rd;
                bus.wdata     <= wdata_c;
                bus.dnpc      <= dnpc_c;
                bus.redirect  <= jump;
            end else if (retire) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_wbu_stage.sv
// Bench for the write-back stage: directed scenarios plus random traffic
// compared against a transaction-level model of the stage.
module tb_ysyx_25020047_wbu_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25020047_wbu_stage_if #(.XLEN(32), .TYPEW(32), .CNTW(64)) bus ();
    ysyx_25020047_wbu_stage_if #(.XLEN(64), .TYPEW(32), .CNTW(4))  bus64 ();

    ysyx_25020047_wbu_stage #(.XLEN(32), .TYPEW(32), .CNTW(64)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    ysyx_25020047_wbu_stage #(.XLEN(64), .TYPEW(32), .CNTW(4)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the stage: held entry, retire count, drain/halt flags
    logic        m_valid, m_wen, m_redir, m_drain, m_halt;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata, m_dnpc, m_retired;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_wb(input logic [31:0] t, input logic [4:0] rd,
                                   input logic [63:0] res, input logic [63:0] mem,
                                   input logic [63:0] pc4, input logic [1:0] lo,
                                   input int xlen, output logic wen,
                                   output logic [63:0] wd, output logic [63:0] dn,
                                   output logic redir);
        logic [63:0] mask, b, h, val;
        logic writes;
        mask   = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        b      = (mem >> (8 * lo)) & 64'hFF;
        h      = (mem >> (16 * lo[1])) & 64'hFFFF;
        writes = 1'b1;
        redir  = 1'b0;
        val    = 64'd0;
        case (t)
            32'h1, 32'h8, 32'h10, 32'h200, 32'h800: val = res;
            32'h2, 32'h400: begin val = pc4; redir = 1'b1; end
            32'h20:   val = mem;
            32'h40:   val = b;
            32'h4000: val = b[7] ? (b | ~64'hFF) : b;
            32'h2000: val = h;
            32'h1000: val = h[15] ? (h | ~64'hFFFF) : h;
            default:  writes = 1'b0;
        endcase
        wen = writes && (rd != 5'd0);
        wd  = wen ? (val & mask) : 64'd0;
        dn  = redir ? res : pc4;
    endfunction

    function automatic logic exp_ready();
        return !m_drain && !m_halt && (!m_valid || bus.out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wen = 0; m_redir = 0; m_drain = 0; m_halt = 0;
        m_waddr = 0; m_wdata = 0; m_dnpc = 0; m_retired = 0;
    endtask

    task automatic set_in(input logic [31:0] t, input logic [4:0] rd, input logic [31:0] res,
                          input logic [31:0] mem, input logic [31:0] pc4, input logic [1:0] lo,
                          input logic v, input logic ordy);
        bus.inst_type = t;   bus.rd = rd;     bus.result = res; bus.memdata = mem;
        bus.snpc = pc4;      bus.addr_lo = lo; bus.in_valid = v; bus.out_ready = ordy;
    endtask

    // One clock: check in_ready before the edge, advance model, compare outputs after
    task automatic cycle(input string tag);
        logic acc, ret, e_wen, e_red;
        logic [63:0] e_wd, e_dn;
        #1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ready()));
        acc = bus.in_valid && exp_ready();
        ret = m_valid && bus.out_ready;
        ref_wb(bus.inst_type, bus.rd, 64'(bus.result), 64'(bus.memdata), 64'(bus.snpc),
               bus.addr_lo, 32, e_wen, e_wd, e_dn, e_red);
        @(posedge clk);
        if (ret) begin
            m_retired = m_retired + 1;
            if (m_drain) begin m_drain = 0; m_halt = 1; end
        end
        if (acc) begin
            m_valid = 1; m_wen = e_wen; m_waddr = bus.rd; m_wdata = e_wd;
            m_dnpc = e_dn; m_redir = e_red;
            if (bus.inst_type == 32'h1_0000) m_drain = 1;
        end else if (ret) begin
            m_valid = 0;
        end
        @(negedge clk);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        check({tag, ".halted"},    64'(bus.halted),    64'(m_halt));
        check({tag, ".retired"},   bus.retired,        m_retired);
        check({tag, ".wen"},       64'(bus.wen),       64'(m_wen));
        check({tag, ".waddr"},     64'(bus.waddr),     64'(m_waddr));
        check({tag, ".wdata"},     64'(bus.wdata),     m_wdata);
        check({tag, ".dnpc"},      64'(bus.dnpc),      m_dnpc);
        check({tag, ".redirect"},  64'(bus.redirect),  64'(m_redir));
    endtask

    // Asynchronous reset applied mid-cycle, away from any clock edge
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.retired",   bus.retired,        64'd0);
        check("rst.halted",    64'(bus.halted),    64'd0);
        check("rst.wen",       64'(bus.wen),       64'd0);
        check("rst.waddr",     64'(bus.waddr),     64'd0);
        check("rst.wdata",     64'(bus.wdata),     64'd0);
        check("rst.dnpc",      64'(bus.dnpc),      64'd0);
        check("rst.redirect",  64'(bus.redirect),  64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] codes [18];
    logic [31:0] ld_t  [4];
    logic [1:0]  ld_lo [4];
    logic [31:0] ld_e  [4];
    logic [63:0] saved;
    int          halt_cycles;

    initial begin
        codes = '{32'h1, 32'h2, 32'h8, 32'h10, 32'h20, 32'h40, 32'h200, 32'h400, 32'h800,
                  32'h1000, 32'h2000, 32'h4000, 32'h8000, 32'h1_0000, 32'h4, 32'h0, 32'h3,
                  32'h1_0020};
        ld_t  = '{32'h4000, 32'h40, 32'h1000, 32'h2000};
        ld_lo = '{2'd3, 2'd1, 2'd2, 2'd2};
        ld_e  = '{32'hFFFF_FF80, 32'h7F, 32'hFFFF_80FF, 32'h80FF};
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        bus64.in_valid = 0; bus64.out_ready = 1; bus64.inst_type = 0; bus64.rd = 0;
        bus64.result = 0; bus64.memdata = 0; bus64.snpc = 0; bus64.addr_lo = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // addi write-back and retire
        set_in(32'h1, 5'd5, 32'h1234, 32'h0, 32'h8000_0004, 2'd0, 1, 1);
        cycle("addi");
        check("addi.wdata", 64'(bus.wdata), 64'h1234);
        check("addi.dnpc",  64'(bus.dnpc),  64'h8000_0004);
        set_in(32'h1, 5'd5, 32'h1234, 32'h0, 32'h8000_0004, 2'd0, 0, 1);
        cycle("addi_ret");
        check("addi.retired", bus.retired, 64'd1);

        // sub-word loads back to back
        for (int i = 0; i < 4; i++) begin
            set_in(ld_t[i], 5'd9, 32'h0, 32'h80FF_7F01, 32'h100, ld_lo[i], 1, 1);
            cycle("load");
            check($sformatf("load%0d.wdata", i), 64'(bus.wdata), 64'(ld_e[i]));
        end

        // jal with rd=1 and rd=0
        set_in(32'h400, 5'd1, 32'h8000_0100, 32'h0, 32'h8000_0004, 2'd0, 1, 1);
        cycle("jal");
        check("jal.wdata", 64'(bus.wdata), 64'h8000_0004);
        check("jal.dnpc",  64'(bus.dnpc),  64'h8000_0100);
        check("jal.redirect", 64'(bus.redirect), 64'd1);
        set_in(32'h400, 5'd0, 32'h8000_0100, 32'h0, 32'h8000_0004, 2'd0, 1, 1);
        cycle("jal_x0");
        check("jal_x0.wen", 64'(bus.wen), 64'd0);

        // backpressure for three cycles, then back-to-back retires
        set_in(32'h8, 5'd3, 32'hAAAA, 32'h0, 32'h200, 2'd0, 1, 0);
        cycle("bp_fill");
        saved = bus.retired;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h800, 5'd4, 32'h5555 + 32'(i), 32'h0, 32'h300, 2'd0, 1, 0);
            cycle("bp_hold");
            check("bp_hold.retired_frozen", bus.retired, saved);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(32'h10, 5'(6 + i), 32'h7000 + 32'(i), 32'h0, 32'h400, 2'd0, 1, 1);
            cycle("bp_stream");
            check("bp_stream.no_bubble", 64'(bus.out_valid), 64'd1);
        end

        // ebreak drains then halts; only reset recovers
        set_in(32'h1_0000, 5'd0, 32'h0, 32'h0, 32'h500, 2'd0, 1, 1);
        cycle("ebreak");
        set_in(32'h1, 5'd7, 32'h99, 32'h0, 32'h504, 2'd0, 1, 1);
        #1;
        check("ebreak.in_ready_low", 64'(bus.in_ready), 64'd0);
        cycle("drain");
        check("ebreak.halted", 64'(bus.halted), 64'd1);
        saved = bus.retired;
        for (int i = 0; i < 3; i++) cycle("halt");
        check("halt.retired_frozen", bus.retired, saved);
        do_reset();

        // reset while draining discards the ebreak entry
        set_in(32'h1_0000, 5'd0, 32'h0, 32'h0, 32'h600, 2'd0, 1, 0);
        cycle("ebreak2");
        set_in(32'h1, 5'd1, 32'h1, 32'h0, 32'h604, 2'd0, 1, 1);
        do_reset();
        cycle("after_drain_rst");

        // random traffic against the model
        halt_cycles = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] t;
            t = codes[$urandom_range(0, 17)];
            if ($urandom_range(0, 19) == 0) t = $urandom;
            set_in(t, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            if (m_halt) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
                halt_cycles = 0;
                do_reset();
            end
            cycle("rnd");
        end

        // 64-bit datapath sign extension and 4-bit counter wrap
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        bus64.inst_type = 32'h4000; bus64.rd = 5'd7; bus64.memdata = 64'h80;
        bus64.addr_lo = 2'd0; bus64.snpc = 64'h4; bus64.in_valid = 1; bus64.out_ready = 1;
        @(posedge clk); @(negedge clk);
        check("x64.lb.wdata", bus64.wdata, 64'hFFFF_FFFF_FFFF_FF80);
        bus64.inst_type = 32'h1;
        for (int i = 0; i < 16; i++) begin
            bus64.result = 64'(i);
            @(posedge clk); @(negedge clk);
        end
        bus64.in_valid = 0;
        @(posedge clk); @(negedge clk);
        check("x64.retired_wrap", 64'(bus64.retired), 64'd1);
        check("x64.out_valid",    64'(bus64.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
